// File: rtl/spi_shift_master.sv
// rtl/spi_shift_master.sv - Mode-0 SPI master shift engine driven by a divided sclk_in
module spi_shift_master #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              spi_sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              sclk_q;
    logic [DATA_W-1:0] tx_shift, tx_shift_d;
    logic [DATA_W-1:0] rx_shift, rx_shift_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic              spi_sclk_d, mosi_d, cs_n_d, busy_d, done_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rise, fall;

    // Edges of the divider clock, seen one clk after sclk_in changes
    assign rise = sclk_in & ~sclk_q;
    assign fall = ~sclk_in & sclk_q;

    // State and every output are registered; reset returns everything to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sclk_q   <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            spi_sclk <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            sclk_q   <= sclk_in;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            bit_cnt  <= bit_cnt_d;
            spi_sclk <= spi_sclk_d;
            mosi     <= mosi_d;
            cs_n     <= cs_n_d;
            rx_data  <= rx_data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Transfer sequencing: wait for a fall to open CS, shift on edges, close CS on the next rise
    always_comb begin
        state_d    = state;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        bit_cnt_d  = bit_cnt;
        spi_sclk_d = spi_sclk;
        mosi_d     = mosi;
        cs_n_d     = cs_n;
        rx_data_d  = rx_data;
        busy_d     = busy;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    tx_shift_d = tx_data;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                // Starting on a fall gives the first bit half a period of setup
                if (fall) begin
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_shift[DATA_W-1];
                    state_d = XFER;
                end
            end
            XFER: begin
                if (rise) begin
                    spi_sclk_d = 1'b1;
                    rx_shift_d = {rx_shift[DATA_W-2:0], miso};
                    bit_cnt_d  = bit_cnt + CNT_W'(1);
                end else if (fall) begin
                    spi_sclk_d = 1'b0;
                    if (bit_cnt == CNT_MAX) begin
                        state_d = TRAIL;
                    end else begin
                        tx_shift_d = tx_shift << 1;
                        mosi_d     = tx_shift[DATA_W-2];
                    end
                end
            end
            TRAIL: begin
                // Half-period CS hold after the last falling edge
                if (rise) begin
                    cs_n_d    = 1'b1;
                    rx_data_d = rx_shift;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    mosi_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_shift_master.sv
// tb/tb_spi_shift_master.sv - directed scoreboard bench for spi_shift_master
module tb_spi_shift_master;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         sclk_in;
    logic         start;
    logic [W-1:0] tx_data;
    logic         miso_val;
    logic         loopback;
    wire          miso;
    logic         spi_sclk;
    logic         mosi;
    logic         cs_n;
    logic [W-1:0] rx_data;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    int  sclk_half = 4;
    logic sclk_hold = 1'b0;
    int  div_cnt = 0;

    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_tx_q[$];
    int           mon_rises = 0;
    logic [W-1:0] mon_mosi = '0;
    int           done_cnt = 0;
    logic         prev_sclk = 1'b0;
    logic         prev_cs = 1'b1;

    assign miso = loopback ? mosi : miso_val;

    spi_shift_master #(.DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk_in  (sclk_in),
        .start    (start),
        .tx_data  (tx_data),
        .miso     (miso),
        .spi_sclk (spi_sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider model: toggles sclk_in every sclk_half clk; a hold parks it low
    initial begin
        sclk_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!sclk_hold || sclk_in) begin
                if (div_cnt >= sclk_half - 1) begin
                    div_cnt = 0;
                    sclk_in = ~sclk_in;
                end else begin
                    div_cnt++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: collects mosi at spi_sclk rises and scores each done against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (prev_cs && !cs_n) begin
                mon_rises = 0;
                mon_mosi  = '0;
            end
            if (!prev_sclk && spi_sclk) begin
                mon_rises++;
                mon_mosi = {mon_mosi[W-2:0], mosi};
            end
            if (done) begin
                done_cnt++;
                if (exp_rx_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_cnt), 32'(0));
                end else begin
                    chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
                    chk("mosi_word", 32'(mon_mosi), 32'(exp_tx_q.pop_front()));
                    chk("sclk_rises", 32'(mon_rises), 32'(W));
                end
            end
            prev_sclk = spi_sclk;
            prev_cs   = cs_n;
        end
    end

    task automatic do_start(input logic [W-1:0] d, input logic push, input logic [W-1:0] rx_exp);
        start   = 1'b1;
        tx_data = d;
        if (push) begin
            exp_tx_q.push_back(d);
            exp_rx_q.push_back(rx_exp);
        end
        @(negedge clk);
        start   = 1'b0;
        tx_data = ~d;
        chk("busy_after_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'(1));
    endtask

    task automatic wait_rises(input int r, input int max);
        int n = 0;
        while (mon_rises != r && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("rise_reached", 32'(mon_rises), 32'(r));
    endtask

    initial begin
        logic snap_mosi;
        int   dc;

        rst      = 1'b1;
        start    = 1'b0;
        tx_data  = '0;
        miso_val = 1'b0;
        loopback = 1'b1;
        sclk_half = 1;

        // Reset with sclk_in toggling
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'(1));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_spi_sclk", 32'(spi_sclk), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_mosi", 32'(mosi), 32'(0));

        // Loopback at divider period 8
        sclk_half = 4;
        repeat (3) @(negedge clk);
        do_start(8'hA5, 1'b1, 8'hA5);
        wait_done(400);
        @(negedge clk);
        chk("a5_busy_after", 32'(busy), 32'(0));
        chk("a5_done_one_cycle", 32'(done), 32'(0));
        chk("a5_cs_n_after", 32'(cs_n), 32'(1));
        chk("a5_mosi_idle", 32'(mosi), 32'(0));

        // Fastest divider, miso held high
        sclk_half = 1;
        loopback  = 1'b0;
        miso_val  = 1'b1;
        repeat (2) @(negedge clk);
        do_start(8'h3C, 1'b1, 8'hFF);
        wait_done(200);
        @(negedge clk);
        chk("3c_busy_after", 32'(busy), 32'(0));

        // Busy guard then back-to-back start in the done cycle
        sclk_half = 4;
        loopback  = 1'b1;
        repeat (2) @(negedge clk);
        dc = done_cnt;
        do_start(8'h11, 1'b1, 8'h11);
        repeat (20) @(negedge clk);
        do_start(8'hFF, 1'b0, 8'h00);
        wait_done(400);
        do_start(8'h5A, 1'b1, 8'h5A);
        wait_done(400);
        @(negedge clk);
        chk("b2b_done_count", 32'(done_cnt - dc), 32'(2));

        // Reset after three rises
        repeat (3) @(negedge clk);
        dc = done_cnt;
        do_start(8'hC3, 1'b0, 8'h00);
        wait_rises(3, 400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_cs_n", 32'(cs_n), 32'(1));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_rx_data", 32'(rx_data), 32'(0));
        repeat (40) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - dc), 32'(0));
        do_start(8'h96, 1'b1, 8'h96);
        wait_done(400);

        // Stall with sclk_in parked low mid-transfer
        repeat (3) @(negedge clk);
        do_start(8'h69, 1'b1, 8'h69);
        wait_rises(4, 400);
        sclk_hold = 1'b1;
        repeat (10) @(negedge clk);
        snap_mosi = mosi;
        repeat (100) @(negedge clk);
        chk("stall_busy", 32'(busy), 32'(1));
        chk("stall_cs_n", 32'(cs_n), 32'(0));
        chk("stall_spi_sclk", 32'(spi_sclk), 32'(0));
        chk("stall_mosi", 32'(mosi), 32'(snap_mosi));
        chk("stall_rises", 32'(mon_rises), 32'(4));
        sclk_hold = 1'b0;
        wait_done(400);
        repeat (4) @(negedge clk);

        chk("queue_drained", 32'(exp_rx_q.size()), 32'(0));
        chk("total_done", 32'(done_cnt), 32'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
